// File: rtl/fnc_vramarbiter.sv
// rtl/fnc_vramarbiter.sv - single-port VRAM arbiter: display fetch priority, CPU req/ack in idle slots
//
// Purpose:
//   Shares one single-port VRAM between the VGA scan-out fetch path and the CPU bus.
//   Display fetches always win the memory slot and have a fixed 3-cycle latency.
//   CPU accesses are granted only in cycles with no display fetch, complete with a
//   one-cycle cpu_ack 3 cycles after grant, and are spaced at least 4 cycles apart.
//   Optional feature macro: VRAMARB_PERFCNT_EN (adds perf_clr / perf_wait).
//
// Ports:
//   clk, rst_n              pixel clock, synchronous active-low reset
//   module_en               0 ignores display requests; CPU path still served
//   disp_req/disp_addr      display fetch request (one word per asserted cycle)
//   disp_data/disp_valid    fetched pixel, registered, 3 cycles after disp_req
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata       completion pulse and read data (held until next ack)
//   mem_en/mem_we/mem_addr/mem_wdata    registered VRAM port
//   mem_rdata               VRAM read data, valid 1 cycle after mem_en
//   perf_clr/perf_wait      (VRAMARB_PERFCNT_EN) clear / blocked-CPU cycle counter

module fnc_vramarbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int VRAM_DEPTH = 307200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              module_en,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAMARB_PERFCNT_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_wait
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(VRAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic disp_slot;
  logic cpu_in_range;
  logic grant;
  logic tag0, tag1;   // display-in-flight tags: memory cycle, read-data cycle
  logic lat_we;       // latched access type of the granted CPU request
  logic lat_oor;      // granted CPU request was out of range

  assign disp_slot    = module_en & disp_req;
  assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH);
  assign grant        = (state_q == IDLE) & cpu_req & ~disp_slot;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tag0       <= 1'b0;
      tag1       <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
    end else begin
      state_q <= state_d;

      // An out-of-range grant still runs the FSM but never touches memory.
      mem_en <= disp_slot | (grant & cpu_in_range);
      mem_we <= grant & cpu_in_range & cpu_we;
      if (disp_slot) begin
        mem_addr <= disp_addr;
      end else if (grant & cpu_in_range) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end

      if (grant) begin
        lat_we  <= cpu_we;
        lat_oor <= ~cpu_in_range;
      end

      tag0       <= disp_slot;
      tag1       <= tag0;
      disp_valid <= tag1;
      if (tag1) disp_data <= mem_rdata;

      cpu_ack <= (state_q == CAPTURE);
      if ((state_q == CAPTURE) && !lat_we) begin
        cpu_rdata <= lat_oor ? '0 : mem_rdata;
      end
    end
  end

`ifdef VRAMARB_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_wait <= '0;
    end else if (perf_clr) begin
      perf_wait <= '0;
    end else if ((state_q == IDLE) && cpu_req && disp_slot && (perf_wait != 16'hFFFF)) begin
      perf_wait <= perf_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fnc_vramarbiter.sv
// tb/tb_fnc_vramarbiter.sv - self-checking bench for fnc_vramarbiter

module tb_fnc_vramarbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        module_en = 1'b1;
  logic        disp_req = 1'b0;
  logic [18:0] disp_addr = '0;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic        perf_clr = 1'b0;
`ifdef VRAMARB_PERFCNT_EN
  logic [15:0] perf_wait;
`endif

  fnc_vramarbiter dut (
    .clk(clk), .rst_n(rst_n), .module_en(module_en),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAMARB_PERFCNT_EN
    , .perf_clr(perf_clr), .perf_wait(perf_wait)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural VRAM: unwritten word a holds a[11:0].
  logic [11:0] vram [int];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) vram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= vram.exists(int'(mem_addr)) ? vram[int'(mem_addr)] : mem_addr[11:0];
    end
  end

  typedef struct packed {
    logic        we;
    logic [18:0] addr;
    logic [11:0] wdata;
  } cpu_txn_t;

  cpu_txn_t cq[$];

  // Reference model: expectations scheduled per cycle in an 8-entry ring.
  logic [11:0] ref_wr [int];
  logic        e_zero [8];
  logic        e_men [8];
  logic        e_mwe [8];
  logic [18:0] e_maddr [8];
  logic [11:0] e_mwdata [8];
  logic        e_dv [8];
  logic [11:0] e_dd [8];
  logic        e_ack [8];
  logic [11:0] e_rd [8];
  int          next_free = 0;
  logic [11:0] last_rd = '0;
  logic [15:0] exp_perf = '0;

  int cyc = 0;
  int compared = 0;
  int failed = 0;
  bit checking = 0;
  int n_dv = 0, n_men = 0, n_ack = 0;

  function automatic logic [11:0] ref_rd(input logic [18:0] a);
    return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : a[11:0];
  endfunction

  task automatic cycle();
    int s, s1, s3;
    logic disp, inr;
    s = cyc % 8;
    if (checking) begin
      if (e_zero[s]) begin
        compared++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data, cpu_ack, cpu_rdata} !== '0) begin
          failed++;
          $display("FAIL reset_outputs cyc=%0d got en=%b we=%b addr=%h wd=%h dv=%b dd=%h ack=%b rd=%h required all 0",
                   cyc, mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data, cpu_ack, cpu_rdata);
        end
      end
      compared++;
      if (mem_en !== e_men[s]) begin
        failed++;
        $display("FAIL mem_en cyc=%0d got %b required %b", cyc, mem_en, e_men[s]);
      end else if (e_men[s]) begin
        compared++;
        if (mem_we !== e_mwe[s] || mem_addr !== e_maddr[s] || (e_mwe[s] && mem_wdata !== e_mwdata[s])) begin
          failed++;
          $display("FAIL mem_access cyc=%0d got we=%b addr=%h wd=%h required we=%b addr=%h wd=%h",
                   cyc, mem_we, mem_addr, mem_wdata, e_mwe[s], e_maddr[s], e_mwdata[s]);
        end
      end
      compared++;
      if (disp_valid !== e_dv[s] || (e_dv[s] && disp_data !== e_dd[s])) begin
        failed++;
        $display("FAIL disp_out cyc=%0d got v=%b d=%h required v=%b d=%h", cyc, disp_valid, disp_data, e_dv[s], e_dd[s]);
      end
      compared++;
      if (cpu_ack !== e_ack[s] || (e_ack[s] && cpu_rdata !== e_rd[s])) begin
        failed++;
        $display("FAIL cpu_out cyc=%0d got ack=%b rd=%h required ack=%b rd=%h", cyc, cpu_ack, cpu_rdata, e_ack[s], e_rd[s]);
      end
`ifdef VRAMARB_PERFCNT_EN
      compared++;
      if (perf_wait !== exp_perf) begin
        failed++;
        $display("FAIL perf_wait cyc=%0d got %h required %h", cyc, perf_wait, exp_perf);
      end
`endif
      if (disp_valid === 1'b1) n_dv++;
      if (mem_en === 1'b1) n_men++;
      if (cpu_ack === 1'b1) n_ack++;
    end
    e_zero[s] = 0; e_men[s] = 0; e_mwe[s] = 0; e_maddr[s] = '0; e_mwdata[s] = '0;
    e_dv[s] = 0; e_dd[s] = '0; e_ack[s] = 0; e_rd[s] = '0;

    // Requester: holds the head request until acked, drops it in the ack cycle.
    if (cpu_ack === 1'b1 && cq.size() > 0) void'(cq.pop_front());
    if (cq.size() > 0 && cpu_ack !== 1'b1) begin
      cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata;
    end else begin
      cpu_req = 1'b0;
    end

    s1 = (cyc + 1) % 8;
    s3 = (cyc + 3) % 8;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        e_men[i] = 0; e_dv[i] = 0; e_ack[i] = 0; e_zero[i] = 0;
      end
      e_zero[s1] = 1;
      next_free = cyc + 1;
      last_rd = '0;
      exp_perf = '0;
      cq.delete();
    end else begin
      disp = module_en & disp_req;
      if (disp) begin
        e_men[s1] = 1; e_mwe[s1] = 0; e_maddr[s1] = disp_addr;
        e_dv[s3] = 1; e_dd[s3] = ref_rd(disp_addr);
      end else if (cpu_req && cyc >= next_free) begin
        inr = (int'(cpu_addr) < 307200);
        if (inr) begin
          e_men[s1] = 1; e_mwe[s1] = cpu_we; e_maddr[s1] = cpu_addr; e_mwdata[s1] = cpu_wdata;
          if (cpu_we) ref_wr[int'(cpu_addr)] = cpu_wdata;
        end
        if (!cpu_we) last_rd = inr ? ref_rd(cpu_addr) : 12'h000;
        e_ack[s3] = 1; e_rd[s3] = last_rd;
        next_free = cyc + 4;
      end
      if (perf_clr) exp_perf = '0;
      else if (cpu_req && disp && cyc >= next_free && exp_perf != 16'hFFFF) exp_perf = exp_perf + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    checking = 1;
    compared++;
    if (mem_en !== 1'b0 || cpu_ack !== 1'b0 || disp_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_state got en=%b ack=%b dv=%b required 0", mem_en, cpu_ack, disp_valid);
    end
    cycle();
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_display();
    int dv0 = n_dv;
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_addr = 19'(i);
      cycle();
    end
    disp_req = 1'b0;
    idle_cycles(5);
    compared++;
    if (n_dv - dv0 != 640) begin
      failed++;
      $display("FAIL display_count got %0d required 640", n_dv - dv0);
    end
  endtask

  task automatic test_cpu_rw();
    int m0 = n_men, a0 = n_ack;
    cq.push_back('{we: 1'b1, addr: 19'h100, wdata: 12'hABC});
    cq.push_back('{we: 1'b0, addr: 19'h100, wdata: 12'h000});
    idle_cycles(12);
    compared++;
    if (n_men - m0 != 2 || n_ack - a0 != 2 || cpu_rdata !== 12'hABC) begin
      failed++;
      $display("FAIL cpu_rw got mem=%0d ack=%0d rd=%h required mem=2 ack=2 rd=abc", n_men - m0, n_ack - a0, cpu_rdata);
    end
  endtask

  task automatic test_contention();
    int a0 = n_ack, dv0 = n_dv;
    cq.push_back('{we: 1'b0, addr: 19'h100, wdata: 12'h000});
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_addr = 19'(1000 + i);
      cycle();
    end
    disp_req = 1'b0;
    compared++;
    if (n_ack != a0) begin
      failed++;
      $display("FAIL contention_blocked got %0d acks required 0", n_ack - a0);
    end
    idle_cycles(6);
    compared++;
    if (n_ack - a0 != 1 || n_dv - dv0 != 640) begin
      failed++;
      $display("FAIL contention_after got ack=%0d dv=%0d required ack=1 dv=640", n_ack - a0, n_dv - dv0);
    end
  endtask

  task automatic test_out_of_range();
    int m0 = n_men;
    cq.push_back('{we: 1'b0, addr: 19'd307200, wdata: 12'h000});
    idle_cycles(6);
    compared++;
    if (cpu_rdata !== 12'h000) begin
      failed++;
      $display("FAIL oor_read got rd=%h required 000", cpu_rdata);
    end
    cq.push_back('{we: 1'b1, addr: 19'd307200, wdata: 12'hFFF});
    idle_cycles(6);
    compared++;
    if (n_men != m0) begin
      failed++;
      $display("FAIL oor_mem got %0d mem cycles required 0", n_men - m0);
    end
  endtask

  task automatic test_reset_mid_access();
    int a0 = n_ack;
    cq.push_back('{we: 1'b0, addr: 19'h100, wdata: 12'h000});
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle_cycles(4);
    compared++;
    if (n_ack != a0) begin
      failed++;
      $display("FAIL reset_drop got %0d acks required 0", n_ack - a0);
    end
    cq.push_back('{we: 1'b0, addr: 19'h100, wdata: 12'h000});
    idle_cycles(6);
    compared++;
    if (n_ack - a0 != 1 || cpu_rdata !== 12'hABC) begin
      failed++;
      $display("FAIL reset_recover got ack=%0d rd=%h required ack=1 rd=abc", n_ack - a0, cpu_rdata);
    end
  endtask

  task automatic test_module_en();
    int dv0 = n_dv;
    for (int i = 0; i < 100; i++) begin
      module_en = !(i >= 40 && i < 60);
      disp_req = 1'b1; disp_addr = 19'(2000 + i);
      cycle();
    end
    disp_req = 1'b0; module_en = 1'b1;
    idle_cycles(5);
    compared++;
    if (n_dv - dv0 != 80) begin
      failed++;
      $display("FAIL module_en_count got %0d required 80", n_dv - dv0);
    end
  endtask

  task automatic test_random();
    logic [18:0] a;
    int a0 = n_ack;
    for (int i = 0; i < 1200; i++) begin
      module_en = ($urandom % 8) != 0;
      disp_req = ($urandom % 3) != 0;
      disp_addr = ($urandom % 2) ? 19'(300 + $urandom % 8) : 19'($urandom_range(0, 307199));
      if (cq.size() == 0 && ($urandom % 3) == 0) begin
        case ($urandom % 4)
          0: a = 19'd307199;
          1: a = 19'($urandom_range(307200, 524287));
          default: a = 19'(300 + $urandom % 8);
        endcase
        cq.push_back('{we: 1'($urandom), addr: a, wdata: 12'($urandom)});
      end
      cycle();
    end
    disp_req = 1'b0;
    idle_cycles(10);
    compared++;
    if (n_ack == a0) begin
      failed++;
      $display("FAIL random_progress got 0 acks required >0");
    end
  endtask

`ifdef VRAMARB_PERFCNT_EN
  task automatic test_perf();
    cq.push_back('{we: 1'b0, addr: 19'h5, wdata: 12'h000});
    disp_req = 1'b1; disp_addr = 19'h7;
    idle_cycles(70000);
    compared++;
    if (perf_wait !== 16'hFFFF) begin
      failed++;
      $display("FAIL perf_saturate got %h required ffff", perf_wait);
    end
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    compared++;
    if (perf_wait !== 16'h0000) begin
      failed++;
      $display("FAIL perf_clear got %h required 0000", perf_wait);
    end
    disp_req = 1'b0;
    idle_cycles(8);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_display();
    test_cpu_rw();
    test_contention();
    test_out_of_range();
    test_reset_mid_access();
    test_module_en();
    test_random();
`ifdef VRAMARB_PERFCNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
